booth2_code_encoder_seq: RTL and testbench
==========================================

// Module: booth2_code_encoder_seq
// PURPOSE
// - Sequential radix-4 Booth encoder: the producing end of the 3-bit Booth-code interface consumed by the booth2 partial-product decoders.
// - Accepts a signed multiplier B and streams one code {b(2i+1), b(2i), b(2i-1)} per beat over a valid/ready handshake, with b(-1) = 0.
// - Sits between the operand-capture stage and the serial partial-product/accumulate datapath of the multi-cycle multiplier variant.
// PARAMETERS
// - WIDTH   16  multiplier width in bits; must be even and >= 4
// - NUM_PP  WIDTH/2  localparam; number of Booth digits per operand
// - IDX_W   $clog2(NUM_PP)  localparam; width of out_idx (3 at default)
// PORTS
// - clk        in   1      single clock, rising edge
// - rst_n      in   1      asynchronous active-low reset; synchronous de-assertion is external
// - in_valid   in   1      B is valid
// - in_ready   out  1      encoder idle and able to accept B
// - in_b       in   WIDTH  signed multiplier B (two's complement)
// - out_valid  out  1      code beat valid
// - out_ready  in   1      consumer accepts the beat
// - out_code   out  3      Booth code {b(2i+1), b(2i), b(2i-1)}; same bit order as the decoder's code input
// - out_idx    out  IDX_W  digit index i; the partial-product weight is 4^i
// - out_neg    out  1      code is 100, 101 or 110 (negative digit)
// - out_zero   out  1      code is 000 or 111 (zero digit)
// - out_last   out  1      final beat for this operand
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_code=0, out_idx=0, out_neg=0, out_zero=1, out_last=0, internal shift register and mask cleared.
// - FSM states: IDLE, ENC.
// - IDLE: in_ready=1. On in_valid & in_ready, load shift register sr[WIDTH:0] <= {in_b, 1'b0}, set idx=0, go to ENC.
// - ENC: in_ready=0; in_valid is ignored and nothing is latched.
// - Latency: first beat has out_valid=1 in the cycle after the accept edge.
// - All out_* are registered or decoded directly from registers; there is no combinational path from in_* or out_ready to any output.
// - out_code = sr[2:0]. out_neg = code[2] & ~(code==3'b111). out_zero = (code==3'b000) | (code==3'b111).
// - On out_valid & out_ready: sr >>= 2 (fill value is don't-care) and idx advances.
//   - If out_last is set, go to IDLE: out_valid=0 and in_ready=1 on the next cycle.
// - Backpressure: while out_valid & ~out_ready, all out_* hold stable. out_valid never drops without a handshake.
// - Throughput: one operand per NUM_PP+1 cycles when out_ready is held at 1. There is no back-to-back accept on the last beat.
// - Default (no macro): every digit is emitted. idx runs 0..NUM_PP-1 and out_last = (idx == NUM_PP-1).
// - Invariant: sum over beats of digit(out_code)*4^out_idx == signed in_b, where digit maps 000/111->0, 001/010->+1, 011->+2, 100->-2, 101/110->-1.
// - Reset mid-operation: the current operand is aborted with no further beats. After release the block is in IDLE.
// CONFIGURATION
// - Macro BOOTH_ZERO_SKIP_EN.
// - Undefined: behaviour as above, always NUM_PP beats per operand.
// - Defined:
//   - At accept, an NUM_PP-bit nonzero mask (one bit per digit) is computed from {in_b, 1'b0} and registered.
//   - Only digits with out_zero=0 are emitted. out_idx carries the true digit index, found by priority-encoding the next set mask bit; sr is indexed accordingly, not shifted by 2 per beat.
//   - out_last = no mask bit set above the current index.
//   - If the mask is all zero (in_b == 0), exactly one beat is emitted: code 000, idx 0, last=1.
//   - Latency to first beat stays 1 cycle. Beat count = max(1, popcount(mask)).
// TESTING
// - in_b=16'h0003, out_ready=1 -> beats (code,idx): (110,0), (001,1), (000,2..7); out_last only on idx 7; in_ready=1 the cycle after.
// - in_b=16'h8000 -> (000,0..6), (100,7) with out_neg=1, last=1; reconstruction gives -32768.
// - in_b=16'h0003, out_ready=0 for 3 cycles while idx=2 -> out_code/out_idx/out_last stable, out_valid stays 1, no beat lost or duplicated.
// - in_valid held high during ENC with a different in_b -> ignored; in_ready=0 until the last handshake completes.
// - rst_n pulsed low while out_idx=4 -> out_valid=0 and in_ready=1 immediately (async); next operand 16'h0001 yields (010,0) first.
// - BOOTH_ZERO_SKIP_EN: in_b=16'h0003 -> (110,0), (001,1,last); in_b=0 -> single (000,0,last); 1000 random signed B values reconstruct exactly, in both builds.

Source files
------------

// File: rtl/booth2_code_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth2_code_encoder_seq
// Description : Sequential radix-4 Booth encoder. Accepts a signed multiplier
//               B over a valid/ready handshake and streams one 3-bit Booth
//               code {b(2i+1), b(2i), b(2i-1)} per beat, with b(-1) = 0.
//               Optional build macro BOOTH_ZERO_SKIP_EN: only nonzero digits
//               are emitted, with out_idx carrying the true digit index.
// Revision    : 1.0 - initial release
// ============================================================================
module booth2_code_encoder_seq #(
    parameter  int WIDTH  = 16,
    localparam int NUM_PP = WIDTH / 2,
    localparam int IDX_W  = (NUM_PP > 1) ? $clog2(NUM_PP) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_code,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_neg,
    output logic             out_zero,
    output logic             out_last
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ENC  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH:0]   r_sr;
    logic [IDX_W-1:0] r_idx;
    logic             w_accept;
    logic             w_advance;
    logic [2:0]       w_code;
    logic             w_last;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_advance = (r_state == S_ENC) && out_ready;

    // State register; async reset aborts any operand in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs, both decoded from the state register
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_ENC;
                end
            end
            S_ENC: begin
                out_valid = 1'b1;
                if (out_ready && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef BOOTH_ZERO_SKIP_EN

    // Remaining nonzero digits strictly above the one currently presented
    logic [NUM_PP-1:0] r_mask;
    logic [WIDTH:0]    w_load_sr;
    logic [NUM_PP-1:0] w_load_mask;
    logic [NUM_PP-1:0] w_load_rest;
    logic [NUM_PP-1:0] w_mask_rest;

    // Index of the lowest set bit; zero when no bit is set
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_PP-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_PP - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    assign w_load_sr = {in_b, 1'b0};

    // Per-digit nonzero flags of the incoming operand
    always_comb begin
        w_load_mask = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            w_load_mask[i] = (w_load_sr[2*i +: 3] != 3'b000) &&
                             (w_load_sr[2*i +: 3] != 3'b111);
        end
    end

    // m & (m - 1) drops the lowest set bit, i.e. the digit being handed out
    assign w_load_rest = w_load_mask & (w_load_mask - 1'b1);
    assign w_mask_rest = r_mask & (r_mask - 1'b1);

    // Operand held unshifted; index jumps to the next nonzero digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr   <= '0;
            r_idx  <= '0;
            r_mask <= '0;
        end else if (w_accept) begin
            r_sr   <= w_load_sr;
            r_idx  <= lowest_set(w_load_mask);
            r_mask <= w_load_rest;
        end else if (w_advance && !w_last) begin
            r_idx  <= lowest_set(r_mask);
            r_mask <= w_mask_rest;
        end
    end

    // Select the 3-bit window of the current digit
    always_comb begin
        w_code = 3'b000;
        for (int i = 0; i < NUM_PP; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_code = r_sr[2*i +: 3];
            end
        end
    end

    assign w_last = (r_mask == '0);

`else

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_PP - 1);

    // Operand shifts right by one digit per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_sr  <= {in_b, 1'b0};
            r_idx <= '0;
        end else if (w_advance) begin
            r_sr  <= {2'b00, r_sr[WIDTH:2]};
            r_idx <= r_idx + 1'b1;
        end
    end

    assign w_code = r_sr[2:0];
    assign w_last = (r_idx == C_LAST_IDX);

`endif

    assign out_code = w_code;
    assign out_idx  = r_idx;
    assign out_neg  = w_code[2] & ~(&w_code);
    assign out_zero = (w_code == 3'b000) | (w_code == 3'b111);
    // Gated so the reset/idle value is 0 regardless of the index registers
    assign out_last = (r_state == S_ENC) & w_last;

endmodule
`default_nettype wire

// File: tb/tb_booth2_code_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth2_code_encoder_seq
// Description : Directed and random self-checking bench for the sequential
//               radix-4 Booth encoder; expectations follow BOOTH_ZERO_SKIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth2_code_encoder_seq;

    localparam int WIDTH = 16;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2:0]       out_code;
    logic [IDX_W-1:0] out_idx;
    logic             out_neg;
    logic             out_zero;
    logic             out_last;

    int checks = 0;
    int errors = 0;

    booth2_code_encoder_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_idx   (out_idx),
        .out_neg   (out_neg),
        .out_zero  (out_zero),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic int digit(input logic [2:0] c);
        case (c)
            3'b001, 3'b010: return 1;
            3'b011:         return 2;
            3'b100:         return -2;
            3'b101, 3'b110: return -1;
            default:        return 0;
        endcase
    endfunction

    function automatic logic exp_neg(input logic [2:0] c);
        return digit(c) < 0;
    endfunction

    function automatic logic exp_zero(input logic [2:0] c);
        return digit(c) == 0;
    endfunction

    // Offer an operand from a falling edge; returns once the rising edge took it
    task automatic accept(input logic [WIDTH-1:0] b, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_b     = b;
            in_valid = 1'b1;
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Sample the next valid beat on a falling edge (bounded wait)
    task automatic get_beat(output logic [2:0] code, output logic [IDX_W-1:0] idx,
                            output logic neg, output logic zero, output logic last,
                            output int waited, output bit ok);
        ok = 1'b0; waited = 0; code = '0; idx = '0; neg = 1'b0; zero = 1'b0; last = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                code = out_code; idx = out_idx; neg = out_neg; zero = out_zero; last = out_last;
                ok = 1'b1;
                break;
            end
            waited++;
        end
    endtask

    task automatic test_reset();
        #22;
        checks++;
        if ({in_ready, out_valid, out_code, out_idx, out_neg, out_zero, out_last} !== {1'b1, 1'b0, 3'b000, 3'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b code=%b idx=%0d neg=%b zero=%b last=%b expected 1 0 000 0 0 1 0",
                     in_ready, out_valid, out_code, out_idx, out_neg, out_zero, out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    // Directed operands 0x0003, 0x8000 and 0x0000 with hand-derived beat lists
    task automatic test_encode();
        logic [WIDTH-1:0] vec [3] = '{16'h0003, 16'h8000, 16'h0000};
        longint           val [3] = '{3, -32768, 0};
        logic [2:0] e_code [8];
        int         e_idx  [8];
        int         n;
        logic [2:0] code; logic [IDX_W-1:0] idx; logic neg, zero, last;
        int waited; bit ok; longint sum;
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < 8; k++) begin e_code[k] = 3'b000; e_idx[k] = k; end
`ifdef BOOTH_ZERO_SKIP_EN
            case (v)
                0: begin n = 2; e_code[0] = 3'b110; e_code[1] = 3'b001; end
                1: begin n = 1; e_code[0] = 3'b100; e_idx[0] = 7; end
                default: begin n = 1; end
            endcase
`else
            n = 8;
            case (v)
                0: begin e_code[0] = 3'b110; e_code[1] = 3'b001; end
                1: begin e_code[7] = 3'b100; end
                default: ;
            endcase
`endif
            accept(vec[v], ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL encode_accept: got no accept for %h expected accept", vec[v]); end
            sum = 0;
            for (int k = 0; k < n; k++) begin
                get_beat(code, idx, neg, zero, last, waited, ok);
                checks++;
                if (!ok || {code, idx, last, neg, zero} !== {e_code[k], 3'(e_idx[k]), k == n - 1, exp_neg(e_code[k]), exp_zero(e_code[k])}) begin
                    errors++;
                    $display("FAIL encode_beat b=%h k=%0d: got ok=%b code=%b idx=%0d last=%b neg=%b zero=%b expected code=%b idx=%0d last=%b",
                             vec[v], k, ok, code, idx, last, neg, zero, e_code[k], e_idx[k], k == n - 1);
                end
                if (k == 0) begin
                    checks++;
                    if (waited != 0) begin errors++; $display("FAIL encode_latency: got %0d wait cycles expected 0", waited); end
                end
                sum += longint'(digit(code)) * (longint'(1) << (2 * idx));
            end
            checks++;
            if (sum != val[v]) begin errors++; $display("FAIL encode_sum b=%h: got %0d expected %0d", vec[v], sum, val[v]); end
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL encode_return_idle b=%h: got rdy=%b vld=%b expected 1 0", vec[v], in_ready, out_valid);
            end
        end
    endtask

    // Stall one beat of 0x0003 and confirm it is held, then delivered exactly once
    task automatic test_backpressure();
        logic [2:0] e_code [8];
        int n, bp;
        logic [2:0] code; logic [IDX_W-1:0] idx; logic neg, zero, last;
        int waited; bit ok;
        for (int k = 0; k < 8; k++) e_code[k] = 3'b000;
        e_code[0] = 3'b110; e_code[1] = 3'b001;
`ifdef BOOTH_ZERO_SKIP_EN
        n = 2; bp = 1;
`else
        n = 8; bp = 2;
`endif
        accept(16'h0003, ok);
        for (int k = 0; k < bp; k++) get_beat(code, idx, neg, zero, last, waited, ok);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_code, out_idx, out_last} !== {1'b1, e_code[bp], 3'(bp), bp == n - 1}) begin
                errors++;
                $display("FAIL bp_hold c=%0d: got vld=%b code=%b idx=%0d last=%b expected 1 %b %0d %b",
                         c, out_valid, out_code, out_idx, out_last, e_code[bp], bp, bp == n - 1);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = bp; k < n; k++) begin
            get_beat(code, idx, neg, zero, last, waited, ok);
            checks++;
            if (!ok || {code, idx, last} !== {e_code[k], 3'(k), k == n - 1}) begin
                errors++;
                $display("FAIL bp_resume k=%0d: got ok=%b code=%b idx=%0d last=%b expected %b %0d %b",
                         k, ok, code, idx, last, e_code[k], k, k == n - 1);
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    // in_valid held with a different operand while encoding must be ignored
    task automatic test_ignore_input();
        logic [2:0] e_code [8];
        int n;
        logic [2:0] code; logic [IDX_W-1:0] idx; logic neg, zero, last;
        int waited; bit ok;
        for (int k = 0; k < 8; k++) e_code[k] = 3'b000;
        e_code[0] = 3'b110; e_code[1] = 3'b001;
`ifdef BOOTH_ZERO_SKIP_EN
        n = 2;
`else
        n = 8;
`endif
        accept(16'h0003, ok);
        in_b = 16'h8000;
        in_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            get_beat(code, idx, neg, zero, last, waited, ok);
            checks++;
            if (!ok || {code, idx, last, in_ready} !== {e_code[k], 3'(k), k == n - 1, 1'b0}) begin
                errors++;
                $display("FAIL ignore_beat k=%0d: got ok=%b code=%b idx=%0d last=%b rdy=%b expected %b %0d %b 0",
                         k, ok, code, idx, last, in_ready, e_code[k], k, k == n - 1);
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ignore_ready_after: got %b expected 1", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ignore_no_accept: got vld=%b expected 0", out_valid); end
    endtask

    // Asynchronous reset at digit 4 of 0x5555, then a fresh operand 0x0001
    task automatic test_reset_midop();
        logic [2:0] code; logic [IDX_W-1:0] idx; logic neg, zero, last;
        int waited; bit ok;
        accept(16'h5555, ok);
        for (int k = 0; k < 5; k++) get_beat(code, idx, neg, zero, last, waited, ok);
        checks++;
        if (!ok || idx !== 3'd4 || code !== 3'b010) begin
            errors++;
            $display("FAIL rst_mid_pre: got ok=%b idx=%0d code=%b expected idx=4 code=010", ok, idx, code);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_idle: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        accept(16'h0001, ok);
        get_beat(code, idx, neg, zero, last, waited, ok);
        checks++;
`ifdef BOOTH_ZERO_SKIP_EN
        if (!ok || {code, idx, last} !== {3'b010, 3'd0, 1'b1}) begin
`else
        if (!ok || {code, idx, last} !== {3'b010, 3'd0, 1'b0}) begin
`endif
            errors++;
            $display("FAIL rst_mid_next: got ok=%b code=%b idx=%0d last=%b expected 010 0", ok, code, idx, last);
        end
        for (int k = 0; k < 8 && !last; k++) get_beat(code, idx, neg, zero, last, waited, ok);
        checks++;
        if (!last) begin errors++; $display("FAIL rst_mid_drain: got last=%b expected 1", last); end
    endtask

    // Edge and random operands: exact reconstruction, beat count, index order
    task automatic test_random();
        logic [WIDTH-1:0] edges [4] = '{16'h0000, 16'h7fff, 16'h8000, 16'hffff};
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   ext;
        logic [2:0] code; logic [IDX_W-1:0] idx; logic neg, zero, last;
        int waited; bit ok;
        longint sum;
        int cnt, exp_cnt, prev, nz;
        bit order_bad;
        for (int t = 0; t < 1004; t++) begin
            b = (t < 4) ? edges[t] : 16'($urandom);
            ext = {b, 1'b0};
            nz = 0;
            for (int i = 0; i < 8; i++) if (digit(ext[2*i +: 3]) != 0) nz++;
`ifdef BOOTH_ZERO_SKIP_EN
            exp_cnt = (nz == 0) ? 1 : nz;
`else
            exp_cnt = 8;
`endif
            accept(b, ok);
            sum = 0; cnt = 0; prev = -1; order_bad = 1'b0; last = 1'b0;
            for (int k = 0; k < 9 && !last && ok; k++) begin
                get_beat(code, idx, neg, zero, last, waited, ok);
                if (ok) begin
                    sum += longint'(digit(code)) * (longint'(1) << (2 * idx));
                    if (int'(idx) <= prev) order_bad = 1'b1;
                    prev = int'(idx);
                    cnt++;
                end
            end
            checks++;
            if (sum != longint'($signed(b))) begin
                errors++;
                $display("FAIL rand_sum b=%h: got %0d expected %0d", b, sum, longint'($signed(b)));
            end
            checks++;
            if (cnt != exp_cnt || order_bad || !last) begin
                errors++;
                $display("FAIL rand_beats b=%h: got cnt=%0d order_bad=%b last=%b expected cnt=%0d ordered last=1",
                         b, cnt, order_bad, last, exp_cnt);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        test_reset();
        test_encode();
        test_backpressure();
        test_ignore_input();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
